// File: rtl/pipeline_pkg.sv
// Shared definitions for the 5-stage RISC-V pipeline.
//   - hz_state_e   : hazard controller FSM states
//   - REG_X0       : architectural zero register index
//   - result_sel_e : writeback result-select encoding; RES_LOAD marks a load
//   - is_load_sel  : helper used by the core top level to derive ex_is_load
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2,
        RES_IMM  = 2'd3
    } result_sel_e;

    function automatic logic is_load_sel(input result_sel_e sel);
        return sel == RES_LOAD;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-high reset.
// Ports:
//   clk   in  clock
//   reset in  synchronous clear
//   en    in  count this cycle
//   count out current value; holds at all-ones once reached
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves, in priority order: multi-cycle data-memory freeze, EX redirect,
// load-use hazard between ID and EX.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   id_valid, id_rs1_addr/rs2_addr,
//   id_uses_rs1/rs2                  instruction in ID and its source usage
//   ex_rd_address, ex_is_load        destination / load flag of EX instruction
//   ex_redirect                      EX resolved a taken branch or jump
//   mem_req                          MEM instruction accesses data memory
//   pc_en, if_id_en, id_ex_en,
//   ex_mem_en                        pipeline register enables (1 = capture)
//   if_id_flush, id_ex_flush         load a bubble instead of capturing
//   pc_sel_redirect                  PC mux selects the EX target
//   stall_cycles, flush_events       saturating performance counters
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd_address,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             mem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pc_sel_redirect,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Wide enough to hold MEM_LAT-2, the number of WAIT cycles.
    localparam int WCNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);
    // With single-cycle memory there is nothing to wait for.
    localparam bit FREEZE_EN = (MEM_LAT > 1);

    hz_state_e         state, state_next;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_next;
    logic              load_use;
    logic              freeze_start;
    logic              live;

    assign load_use = id_valid && ex_is_load && (ex_rd_address != REG_X0) &&
                      ((id_uses_rs1 && (id_rs1_addr == ex_rd_address)) ||
                       (id_uses_rs2 && (id_rs2_addr == ex_rd_address)));

    // Only RUN accepts a new access; in RELEASE mem_req is the same access.
    assign freeze_start = FREEZE_EN && mem_req && (state == RUN);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        unique case (state)
            RUN: begin
                if (freeze_start) begin
                    if (MEM_LAT > 2) begin
                        state_next    = WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end else begin
                        state_next = RELEASE;
                    end
                end
            end
            WAIT: begin
                // The counter reaches zero on the edge into RELEASE, so the
                // freeze covers exactly MEM_LAT-1 cycles including entry.
                wait_cnt_next = wait_cnt - 1'b1;
                if (wait_cnt <= WCNT_W'(1)) begin
                    state_next    = RELEASE;
                    wait_cnt_next = '0;
                end
            end
            RELEASE: state_next = RUN;
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // ---------------- output logic ----------------
    // Enables are live in RELEASE, and in RUN unless a freeze starts now.
    assign live = !reset && ((state == RELEASE) || ((state == RUN) && !freeze_start));

    always_comb begin
        pc_en           = 1'b0;
        if_id_en        = 1'b0;
        id_ex_en        = 1'b0;
        ex_mem_en       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        pc_sel_redirect = 1'b0;
        if (live) begin
            if (ex_redirect) begin
                // Redirect overrides load-use: both younger slots are squashed.
                pc_en           = 1'b1;
                if_id_en        = 1'b1;
                id_ex_en        = 1'b1;
                ex_mem_en       = 1'b1;
                if_id_flush     = 1'b1;
                id_ex_flush     = 1'b1;
                pc_sel_redirect = 1'b1;
            end else if (load_use) begin
                // Hold PC and IF/ID; the load advances, a bubble enters EX.
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end
    end

    // ---------------- performance counters ----------------
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (!pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pc_sel_redirect),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with MEM_LAT=4.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_LAT = 4;
    localparam int CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs1_addr, id_rs2_addr;
    logic             id_uses_rs1, id_uses_rs2;
    logic [4:0]       ex_rd_address;
    logic             ex_is_load, ex_redirect, mem_req;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic             if_id_flush, id_ex_flush, pc_sel_redirect;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    pipeline_hazard_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd_address   (ex_rd_address),
        .ex_is_load      (ex_is_load),
        .ex_redirect     (ex_redirect),
        .mem_req         (mem_req),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .pc_sel_redirect (pc_sel_redirect),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    always #5 clk = ~clk;

    // ctl bit order: {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, pc_sel_redirect}
    typedef struct packed {
        logic [6:0]       ctl;
        logic [CNT_W-1:0] stall;
        logic [CNT_W-1:0] flush;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: remaining freeze cycles plus a release flag.
    int               m_hold  = 0;
    bit               m_rel   = 1'b0;
    logic [CNT_W-1:0] m_stall = '0;
    logic [CNT_W-1:0] m_flush = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic iv,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd, input logic ld,
                         input logic rdr, input logic mrq);
        logic [6:0] c;
        logic       lu;
        exp_t       e;
        @(negedge clk);
        cyc++;
        reset = rst; id_valid = iv; id_rs1_addr = rs1; id_rs2_addr = rs2;
        id_uses_rs1 = u1; id_uses_rs2 = u2; ex_rd_address = rd;
        ex_is_load = ld; ex_redirect = rdr; mem_req = mrq;

        lu = iv && ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (rst) begin
            c = 7'b0000000; m_hold = 0; m_rel = 1'b0;
        end else if (m_hold > 0) begin
            c = 7'b0000000;
            m_hold--;
            if (m_hold == 0) m_rel = 1'b1;
        end else if (!m_rel && mrq && MEM_LAT > 1) begin
            c = 7'b0000000;
            m_hold = MEM_LAT - 2;
            m_rel  = (m_hold == 0);
        end else begin
            m_rel = 1'b0;
            if (rdr)     c = 7'b1111111;
            else if (lu) c = 7'b0011010;
            else         c = 7'b1111000;
        end
        sb_q.push_back('{ctl: c, stall: m_stall, flush: m_flush});

        if (rst) begin
            m_stall = '0; m_flush = '0;
        end else begin
            if (!c[6] && m_stall != '1) m_stall++;
            if (c[0]  && m_flush != '1) m_flush++;
        end

        #1;
        e = sb_q.pop_front();
        check($sformatf("ctl@%0d", cyc),
              {57'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, pc_sel_redirect},
              {57'd0, e.ctl});
        check($sformatf("stall@%0d", cyc), 64'(stall_cycles), 64'(e.stall));
        check($sformatf("flush@%0d", cyc), 64'(flush_events), 64'(e.flush));
    endtask

    task automatic idle(input logic rst);
        drive(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_rd_address = 0;
        ex_is_load = 0; ex_redirect = 0; mem_req = 0;
        @(posedge clk);

        // Reset held 3 cycles, then idle.
        repeat (3) idle(1);
        repeat (2) idle(0);

        // Load-use on rs2 = x5: one stall cycle.
        drive(0, 1, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0);
        idle(0);
        check("stall_after_lu", 64'(stall_cycles), 64'd1);
        // Same with rd = x0: no stall.
        drive(0, 1, 5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0);
        idle(0);
        check("stall_x0", 64'(stall_cycles), 64'd1);

        // mem_req held T..T+3: freeze T..T+2, RELEASE at T+3, no re-freeze.
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        check("stall_after_freeze", 64'(stall_cycles), 64'd4);

        // mem_req + redirect at T: redirect applied in RELEASE.
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(0);
        check("flush_after_freeze", 64'(flush_events), 64'd1);
        check("stall_after_freeze2", 64'(stall_cycles), 64'd7);

        // Redirect with a load-use match: redirect wins, no stall.
        drive(0, 1, 5'd7, 5'd0, 1, 0, 5'd7, 1, 1, 0);
        idle(0);
        check("stall_redir_lu", 64'(stall_cycles), 64'd7);
        check("flush_redir_lu", 64'(flush_events), 64'd2);

        // Reset at T+1 of a freeze, then a fresh 3-cycle freeze.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        check("stall_fresh_freeze", 64'(stall_cycles), 64'd3);

        // Random mix of all conditions.
        for (int i = 0; i < 80; i++) begin
            drive(0, 1'($urandom_range(1)),
                  5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  5'($urandom_range(3)), 1'($urandom_range(1)),
                  ($urandom_range(4) == 0), ($urandom_range(7) == 0));
        end
        repeat (4) idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It sequences the enables and bubble-inserts of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It resolves three conditions:
- load-use hazards between ID and EX,
- control redirects resolved in EX,
- multi-cycle data-memory accesses, using a latency counter that freezes the whole pipeline.

It sits beside the datapath in the core top level and drives the pipeline registers' enable and flush inputs.

## Interface
Parameters:
- MEM_LAT, 2, data-memory access latency in cycles (≥1); the pipeline freezes for MEM_LAT-1 cycles per access.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  instruction in ID reads rs1 / rs2
- ex_rd_address  in  5  destination register of the instruction in EX
- ex_is_load  in  1  instruction in EX is a load (result select = load data)
- ex_redirect  in  1  EX resolved a taken branch or jump; PC must load the target
- mem_req  in  1  instruction in MEM performs a data-memory load or store
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register enables (1 = capture)
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all-zero controls) instead of capturing
- pc_sel_redirect  out  1  PC mux selects the EX target
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0
- flush_events  out  CNT_W  saturating count of accepted redirects

## Operation
FSM states: RUN, WAIT, RELEASE.

- Reset, while `reset`=1:
  - state=RUN, wait counter=0, both counters=0.
  - All enables, flushes and pc_sel_redirect are 0.
- RUN:
  - mem_req=1 and MEM_LAT>1: freeze.
    - All four enables are 0 and no flush is issued.
    - Load wait counter with MEM_LAT-2 and go to WAIT; if MEM_LAT=2, go straight to RELEASE.
  - mem_req=1 and MEM_LAT=1: mem_req is ignored.
  - Otherwise ex_redirect=1: all enables=1, if_id_flush=1, id_ex_flush=1, pc_sel_redirect=1. flush_events increments.
  - Otherwise load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1.
    - Load-use hazard = id_valid && ex_is_load && ex_rd_address≠0 && ((id_uses_rs1 && id_rs1_addr==ex_rd_address) || (id_uses_rs2 && id_rs2_addr==ex_rd_address)).
  - Otherwise all enables=1, no flush.
- WAIT:
  - Full freeze: all enables 0.
  - ex_redirect, load-use and mem_req are ignored.
  - Counter decrements each cycle; at counter==0 go to RELEASE.
- RELEASE:
  - mem_req is ignored, because it is the same, still-present access.
  - ex_redirect and load-use are evaluated exactly as in RUN.
  - Always return to RUN.
- Priority, highest first: freeze > redirect > load-use.
  - A redirect that coincides with a freeze is applied in RELEASE. This works because EX is held, so ex_redirect stays asserted.
  - A redirect and a load-use in the same cycle: the redirect wins and no stall is inserted.
- Counters:
  - stall_cycles increments on every non-reset cycle with pc_en=0.
  - Both counters saturate at all-ones and never wrap.
- Reset mid-freeze aborts the access sequence. The next cycle is RUN with the counter cleared.

## Timing
- All outputs are combinational from the registered state and the current inputs, valid in the same cycle.
- Counters are registered and reflect a cycle's event one cycle later.
- A memory access accepted in cycle T freezes cycles T..T+MEM_LAT-2. Cycle T+MEM_LAT-1 is RELEASE, with enables live.
- A load-use stall lasts exactly 1 cycle. On the next cycle the load has left EX, so the hazard condition clears.
- A redirect costs 2 bubbles, the ID and EX slots.

## Structure
- A shared package (`pipeline_pkg`) holds:
  - the state enum: RUN=2'd0, WAIT=2'd1, RELEASE=2'd2;
  - the x0 constant 5'd0;
  - the result-select encoding for load, which the top level uses to derive ex_is_load.
- One sub-module, `sat_counter`: a CNT_W-wide saturating incrementer with enable and synchronous reset, instantiated twice.

## Test plan
- Reset held 3 cycles, then released, with no inputs active: during reset every output is 0 and the counters read 0; after release all enables are 1.
- ex_is_load=1, ex_rd_address=5, id_valid=1, id_uses_rs2=1, id_rs2_addr=5: one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. stall_cycles=1 the next cycle. Repeating with ex_rd_address=0 gives no stall.
- MEM_LAT=4, mem_req held high from T: enables are 0 in T, T+1 and T+2; RELEASE at T+3 with enables 1 and no re-freeze; stall_cycles=3.
- MEM_LAT=4, mem_req and ex_redirect both high at T: no flush during T..T+2; at T+3 if_id_flush=id_ex_flush=pc_sel_redirect=1 and flush_events=1.
- ex_redirect together with a load-use match: flushes asserted, pc_en=1, and stall_cycles unchanged.
- Reset asserted at T+1 of a MEM_LAT=4 freeze: state is RUN after release. A subsequent mem_req starts a fresh 3-cycle freeze.
